pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 17 +
 rtl/pc_sequencer_next_calc.sv | 34 +++
 rtl/pc_sequencer.sv | 106 ++++++++++
 tb/tb_pc_sequencer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared state encodings, PC defaults and CPU control constants
package pc_sequencer_pkg;

  localparam int PC_W        = 32;
  localparam int JUMP_TGT_W  = 26;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam logic [PC_W-1:0] IRQ_VECTOR_DEFAULT = 32'h0000_0800;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2,
    ST_IRQ   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/pc_sequencer_next_calc.sv
// rtl/pc_sequencer_next_calc.sv - combinational next-PC select: eret > jr > jump > branch > sequential
module pc_next_calc
  import pc_sequencer_pkg::*;
(
  input  logic [31:0] in_pc,
  input  logic [31:0] in_epc,
  input  logic        in_branch_taken,
  input  logic [31:0] in_extended,
  input  logic        in_jump,
  input  logic [25:0] in_jump_target,
  input  logic        in_jr,
  input  logic [31:0] in_jr_addr,
  input  logic        in_eret,
  output logic [31:0] out_next_pc
);

  logic [31:0] seq_pc;

  assign seq_pc = in_pc + 32'd1;

  always_comb begin
    out_next_pc = seq_pc;
    if (in_eret) begin
      out_next_pc = in_epc;
    end else if (in_jr) begin
      out_next_pc = in_jr_addr;
    end else if (in_jump) begin
      out_next_pc = {in_pc[31:26], in_jump_target};
    end else if (in_branch_taken) begin
      out_next_pc = seq_pc + in_extended;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC sequencer with stall, halt and single-level interrupt FSM
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = pc_sequencer_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] IRQ_VECTOR = pc_sequencer_pkg::IRQ_VECTOR_DEFAULT
) (
  input  logic        in_clk,
  input  logic        in_rst_n,
  input  logic        in_stall,
  input  logic        in_branch_taken,
  input  logic [31:0] in_extended,
  input  logic        in_jump,
  input  logic [25:0] in_jump_target,
  input  logic        in_jr,
  input  logic [31:0] in_jr_addr,
  input  logic        in_halt,
  input  logic        in_go,
  input  logic        in_irq,
  input  logic        in_eret,
  output logic [31:0] out_pc,
  output logic [31:0] out_epc,
  output logic        out_pc_valid,
  output logic        out_halted,
  output logic        out_irq_ack,
  output logic [1:0]  out_state
);
  import pc_sequencer_pkg::*;

  seq_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic        ie_q, ie_d;
  logic        valid_q, valid_d;
  logic [31:0] next_pc;
  logic        active;

  pc_next_calc u_next (
    .in_pc           (pc_q),
    .in_epc          (epc_q),
    .in_branch_taken (in_branch_taken),
    .in_extended     (in_extended),
    .in_jump         (in_jump),
    .in_jump_target  (in_jump_target),
    .in_jr           (in_jr),
    .in_jr_addr      (in_jr_addr),
    .in_eret         (in_eret),
    .out_next_pc     (next_pc)
  );

  // RUN with valid_q low only happens right after reset: RESET_PC has not been fetched yet.
  assign active = ((state_q == ST_RUN) && valid_q) || (state_q == ST_STALL);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    ie_d    = ie_q;
    if (state_q == ST_HALT) begin
      if (in_go) state_d = ST_RUN;
    end else if (state_q == ST_IRQ) begin
      state_d = ST_RUN;
      pc_d    = pc_q + 32'd1;
    end else if (active) begin
      if (in_halt) begin
        state_d = ST_HALT;
        pc_d    = pc_q + 32'd1;
      end else if (in_irq && ie_q && ((state_q == ST_RUN) || !in_stall)) begin
        // A stalled instruction has not completed, so it is the one to resume at.
        state_d = ST_IRQ;
        pc_d    = IRQ_VECTOR;
        epc_d   = in_stall ? pc_q : next_pc;
        ie_d    = 1'b0;
      end else if (in_stall) begin
        state_d = ST_STALL;
      end else begin
        state_d = ST_RUN;
        pc_d    = next_pc;
        if (in_eret) ie_d = 1'b1;
      end
    end
    valid_d = (state_d == ST_RUN) || (state_d == ST_IRQ);
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      epc_q   <= 32'd0;
      ie_q    <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      ie_q    <= ie_d;
      valid_q <= valid_d;
    end
  end

  assign out_pc       = pc_q;
  assign out_epc      = epc_q;
  assign out_pc_valid = valid_q;
  assign out_halted   = (state_q == ST_HALT);
  assign out_irq_ack  = (state_q == ST_IRQ);
  assign out_state    = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

  logic        in_clk = 1'b0;
  logic        in_rst_n;
  logic        in_stall, in_branch_taken, in_jump, in_jr, in_halt, in_go, in_irq, in_eret;
  logic [31:0] in_extended, in_jr_addr;
  logic [25:0] in_jump_target;
  logic [31:0] out_pc, out_epc;
  logic        out_pc_valid, out_halted, out_irq_ack;
  logic [1:0]  out_state;

  int total = 0;
  int bad   = 0;

  pc_sequencer dut (
    .in_clk          (in_clk),
    .in_rst_n        (in_rst_n),
    .in_stall        (in_stall),
    .in_branch_taken (in_branch_taken),
    .in_extended     (in_extended),
    .in_jump         (in_jump),
    .in_jump_target  (in_jump_target),
    .in_jr           (in_jr),
    .in_jr_addr      (in_jr_addr),
    .in_halt         (in_halt),
    .in_go           (in_go),
    .in_irq          (in_irq),
    .in_eret         (in_eret),
    .out_pc          (out_pc),
    .out_epc         (out_epc),
    .out_pc_valid    (out_pc_valid),
    .out_halted      (out_halted),
    .out_irq_ack     (out_irq_ack),
    .out_state       (out_state)
  );

  always #5 in_clk = ~in_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic jump_to(input logic [25:0] tgt);
    in_jump = 1'b1;
    in_jump_target = tgt;
    tick();
    in_jump = 1'b0;
  endtask

  initial begin
    in_rst_n = 1'b0;
    {in_stall, in_branch_taken, in_jump, in_jr, in_halt, in_go, in_irq, in_eret} = '0;
    in_extended = '0;
    in_jr_addr = '0;
    in_jump_target = '0;
    #12;
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_epc", out_epc, 32'd0);
    chk("rst_valid", {31'd0, out_pc_valid}, 32'd0);
    chk("rst_state", {30'd0, out_state}, 32'd0);
    chk("rst_halted", {31'd0, out_halted}, 32'd0);
    chk("rst_ack", {31'd0, out_irq_ack}, 32'd0);
    @(negedge in_clk);
    in_rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      tick();
      chk("seq_pc", out_pc, i);
      chk("seq_valid", {31'd0, out_pc_valid}, 32'd1);
    end

    jump_to(26'd10);
    chk("jump10", out_pc, 32'd10);
    in_branch_taken = 1'b1;
    in_extended = -32'sd4;
    tick();
    in_branch_taken = 1'b0;
    chk("branch_back", out_pc, 32'd7);
    jump_to(26'h40);
    chk("jump40", out_pc, 32'h40);

    jump_to(26'd5);
    in_stall = 1'b1;
    in_jump = 1'b1;
    in_jump_target = 26'd99;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_pc", out_pc, 32'd5);
      chk("stall_valid", {31'd0, out_pc_valid}, 32'd0);
      chk("stall_state", {30'd0, out_state}, 32'd1);
    end
    in_jump = 1'b0;
    in_stall = 1'b0;
    tick();
    chk("stall_release", out_pc, 32'd6);
    chk("stall_rel_valid", {31'd0, out_pc_valid}, 32'd1);

    jump_to(26'd20);
    in_irq = 1'b1;
    tick();
    chk("irq_pc", out_pc, 32'h800);
    chk("irq_epc", out_epc, 32'd21);
    chk("irq_ack", {31'd0, out_irq_ack}, 32'd1);
    chk("irq_state", {30'd0, out_state}, 32'd3);
    chk("irq_valid", {31'd0, out_pc_valid}, 32'd1);
    tick();
    chk("irq_after_pc", out_pc, 32'h801);
    chk("irq_ack_drop", {31'd0, out_irq_ack}, 32'd0);
    tick();
    chk("nested_blocked", out_pc, 32'h802);
    chk("nested_state", {30'd0, out_state}, 32'd0);
    in_eret = 1'b1;
    tick();
    in_eret = 1'b0;
    in_irq = 1'b0;
    chk("eret_pc", out_pc, 32'd21);

    jump_to(26'd30);
    in_halt = 1'b1;
    tick();
    in_halt = 1'b0;
    in_irq = 1'b1;
    chk("halt_flag", {31'd0, out_halted}, 32'd1);
    chk("halt_valid", {31'd0, out_pc_valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("halt_pc", out_pc, 32'd31);
      chk("halt_state", {30'd0, out_state}, 32'd2);
    end
    in_irq = 1'b0;
    in_go = 1'b1;
    tick();
    in_go = 1'b0;
    chk("go_pc", out_pc, 32'd31);
    chk("go_valid", {31'd0, out_pc_valid}, 32'd1);
    tick();
    chk("go_next", out_pc, 32'd32);

    in_jr = 1'b1;
    in_jr_addr = 32'hFFFF_FFFF;
    tick();
    in_jr = 1'b0;
    chk("jr_pc", out_pc, 32'hFFFF_FFFF);
    tick();
    chk("wrap", out_pc, 32'd0);

    in_irq = 1'b1;
    tick();
    in_irq = 1'b0;
    chk("irq2_state", {30'd0, out_state}, 32'd3);
    #2;
    in_rst_n = 1'b0;
    #1;
    chk("async_rst_pc", out_pc, 32'd0);
    chk("async_rst_state", {30'd0, out_state}, 32'd0);
    chk("async_rst_ack", {31'd0, out_irq_ack}, 32'd0);
    chk("async_rst_epc", out_epc, 32'd0);
    chk("async_rst_valid", {31'd0, out_pc_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
